// File: rtl/sar_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_conv_ctrl
// Purpose  : Conversion sequencer for the 8-bit SAR ADC. Sequences sampling,
//            SAR reset/enable and comparator decision counting with a per-bit
//            timeout, then presents the captured result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module sar_conv_ctrl #(
    parameter int N_DEC         = 7,
    parameter int DW            = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont_mode,
    input  logic          Op,
    input  logic          Om,
    input  logic [DW-1:0] sar_d,
    output logic          sample,
    output logic          sar_rst,
    output logic          sar_en,
    output logic          busy,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          res_valid,
    input  logic          res_ready
);

    // Counter widths hold the terminal count itself.
    localparam int c_DEC_W = $clog2(N_DEC + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);
    localparam int c_SMP_W = $clog2(SAMPLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DEC_W-1:0]   r_dec_cnt;
    logic [c_DEC_W-1:0]   w_dec_cnt_nxt;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [c_TO_W-1:0]    w_to_cnt_nxt;
    logic [c_SMP_W-1:0]   r_smp_cnt;
    logic [c_SMP_W-1:0]   w_smp_cnt_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    logic                 r_sample;
    logic                 r_sar_rst;
    logic                 r_sar_en;
    logic                 r_busy;
    logic [DW-1:0]        r_res_data;
    logic                 r_res_err;
    logic                 r_res_valid;

    logic                 w_decision;
    logic                 w_accept;

    // A comparator decision is exactly one of the two outputs being high.
    assign w_decision = Op ^ Om;
    assign w_accept   = r_res_valid & res_ready;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dec_cnt <= '0;
            r_to_cnt  <= '0;
            r_smp_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dec_cnt <= w_dec_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_smp_cnt <= w_smp_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state, counter and error-flag logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_dec_cnt_nxt = r_dec_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_smp_cnt_nxt = r_smp_cnt;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_SAMPLE;
                    w_smp_cnt_nxt = '0;
                    w_dec_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                    w_err_nxt     = 1'b0;
                end
            end
            S_SAMPLE: begin
                if (r_smp_cnt == c_SMP_W'(SAMPLE_CYCLES - 1)) begin
                    w_state_nxt = S_CONVERT;
                end else begin
                    w_smp_cnt_nxt = r_smp_cnt + c_SMP_W'(1);
                end
            end
            S_CONVERT: begin
                if (w_decision) begin
                    w_dec_cnt_nxt = r_dec_cnt + c_DEC_W'(1);
                    w_to_cnt_nxt  = '0;
                    if (r_dec_cnt == c_DEC_W'(N_DEC - 1)) begin
                        w_state_nxt = S_CAPTURE;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
                    if (r_to_cnt == c_TO_W'(TIMEOUT - 1)) begin
                        w_state_nxt = S_CAPTURE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept) begin
                    w_err_nxt = 1'b0;
                    if (cont_mode) begin
                        w_state_nxt   = S_SAMPLE;
                        w_smp_cnt_nxt = '0;
                        w_dec_cnt_nxt = '0;
                        w_to_cnt_nxt  = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state so they line up
    // with the state register; result captured on the CAPTURE exit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample    <= 1'b0;
            r_sar_rst   <= 1'b1;
            r_sar_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_sample  <= (w_state_nxt == S_SAMPLE);
            r_sar_rst <= !((w_state_nxt == S_CONVERT) || (w_state_nxt == S_CAPTURE));
            r_sar_en  <= (w_state_nxt == S_CONVERT);
            r_busy    <= (w_state_nxt != S_IDLE);
            if (r_state == S_CAPTURE) begin
                r_res_data  <= sar_d;
                r_res_err   <= r_err;
                r_res_valid <= 1'b1;
            end else if ((r_state == S_DONE) && w_accept) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign sample    = r_sample;
    assign sar_rst   = r_sar_rst;
    assign sar_en    = r_sar_en;
    assign busy      = r_busy;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_sar_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_conv_ctrl
// Purpose  : Self-checking bench for sar_conv_ctrl. Each conversion is
//            planned as a decision schedule; the expected CONVERT length and
//            error flag come from counting decisions and idle runs in it, and
//            the expected output timeline follows from those numbers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_conv_ctrl;

    localparam int N_DEC   = 7;
    localparam int DW      = 8;
    localparam int SC      = 4;
    localparam int TO      = 15;

    // Expected {sample, sar_rst, sar_en, busy, res_valid} per phase.
    localparam logic [4:0] c_IDLE = 5'b01000;
    localparam logic [4:0] c_SMP  = 5'b11010;
    localparam logic [4:0] c_CONV = 5'b00110;
    localparam logic [4:0] c_CAPT = 5'b00010;
    localparam logic [4:0] c_DONE = 5'b01011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cont_mode;
    logic          Op;
    logic          Om;
    logic [DW-1:0] sar_d;
    logic          sample;
    logic          sar_rst;
    logic          sar_en;
    logic          busy;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic          res_valid;
    logic          res_ready;

    int tests = 0;
    int fails = 0;

    sar_conv_ctrl #(
        .N_DEC(N_DEC), .DW(DW), .SAMPLE_CYCLES(SC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode),
        .Op(Op), .Om(Om), .sar_d(sar_d), .sample(sample), .sar_rst(sar_rst),
        .sar_en(sar_en), .busy(busy), .res_data(res_data), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {sample, sar_rst, sar_en, busy, res_valid};
    endfunction

    // Drive comparator outputs: decision = exactly one side high.
    task automatic drive_cmp(input bit dec);
        logic v;
        v  = 1'($urandom);
        Op = v;
        Om = dec ? ~v : v;
    endtask

    // Start from IDLE: the edge that samples start is edge 1 of the conversion.
    task automatic start_conv();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entry: settled in cycle 1 of SAMPLE. mode 0 nominal, 1 stalled, 2 timeout.
    task automatic run_conv(input int mode, input logic [DW-1:0] dval,
                            input int ready_delay, input bit spam_start,
                            input bit cont_after);
        bit pat[$];
        int L;
        bit err;
        int ndec;
        int run;
        pat.delete();
        if (mode == 2) begin
            for (int k = 0; k < 3; k++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) pat.push_back(1'b0);
                pat.push_back(1'b1);
            end
            for (int g = 0; g < TO + 5; g++) pat.push_back(1'b0);
        end else begin
            for (int k = 0; k < N_DEC; k++) begin
                if (mode == 1 && k > 0) begin
                    for (int g = 0; g < 3; g++) pat.push_back(1'b0);
                end
                pat.push_back(1'b1);
            end
        end
        // Reference: conversion ends at the N_DEC-th decision, or after TO
        // consecutive cycles without one (then flagged as partial).
        L = pat.size(); err = 1'b0; ndec = 0; run = 0;
        for (int j = 0; j < pat.size(); j++) begin
            if (pat[j]) begin
                ndec++; run = 0;
                if (ndec == N_DEC) begin L = j + 1; break; end
            end else begin
                run++;
                if (run == TO) begin L = j + 1; err = 1'b1; break; end
            end
        end

        for (int c = 1; c <= SC; c++) begin
            chk($sformatf("sample_c%0d", c), 32'(ctl()), 32'(c_SMP));
            drive_cmp(1'($urandom));
            sar_d = DW'($urandom);
            res_ready = 1'($urandom);
            step();
        end
        for (int j = 0; j < L; j++) begin
            chk($sformatf("convert_j%0d", j), 32'(ctl()), 32'(c_CONV));
            drive_cmp(pat[j]);
            sar_d = DW'($urandom);
            res_ready = 1'($urandom);
            step();
        end
        chk("capture", 32'(ctl()), 32'(c_CAPT));
        sar_d = dval;
        res_ready = 1'b0;
        drive_cmp(1'($urandom));
        step();
        for (int d = 0; d <= ready_delay; d++) begin
            chk($sformatf("done_ctl_d%0d", d), 32'(ctl()), 32'(c_DONE));
            chk($sformatf("res_data_d%0d", d), 32'(res_data), 32'(dval));
            chk($sformatf("res_err_d%0d", d), 32'(res_err), 32'(err));
            res_ready = (d == ready_delay);
            cont_mode = (d == ready_delay) ? cont_after : 1'($urandom);
            if (spam_start) start = 1'($urandom);
            sar_d = DW'($urandom);
            drive_cmp(1'($urandom));
            step();
        end
        start = 1'b0;
        res_ready = 1'b0;
        chk("after_handshake", 32'(ctl()), 32'(cont_after ? c_SMP : c_IDLE));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; Op = 1'b0; Om = 1'b0;
        sar_d = '0; res_ready = 1'b0;
        step();
        step();
        chk("reset_ctl", 32'(ctl()), 32'(c_IDLE));
        chk("reset_data", 32'(res_data), 32'h0);
        chk("reset_err", 32'(res_err), 32'h0);
        rst_n = 1'b1;

        // Idle with noise on every other input: nothing happens.
        for (int i = 0; i < 3; i++) begin
            drive_cmp(1'($urandom));
            res_ready = 1'($urandom);
            cont_mode = 1'($urandom);
            step();
            chk("idle_hold", 32'(ctl()), 32'(c_IDLE));
        end
        res_ready = 1'b0;

        // Nominal, stalled, timeout, backpressure with ignored starts.
        start_conv(); run_conv(0, 8'hA5, 0, 1'b0, 1'b0);
        start_conv(); run_conv(1, 8'h3C, 1, 1'b0, 1'b0);
        start_conv(); run_conv(2, 8'h5A, 0, 1'b0, 1'b0);
        start_conv(); run_conv(0, 8'hC3, 10, 1'b1, 1'b0);
        step();
        chk("idle_after_bp", 32'(ctl()), 32'(c_IDLE));

        // Continuous mode: three back-to-back results, drop to IDLE after 3rd.
        start_conv();
        run_conv(0, 8'h11, 0, 1'b0, 1'b1);
        run_conv(1, 8'h22, 2, 1'b0, 1'b1);
        run_conv(0, 8'h33, 0, 1'b0, 1'b0);

        // Randomized conversions.
        for (int n = 0; n < 6; n++) begin
            start_conv();
            run_conv(int'($urandom_range(0, 2)), DW'($urandom),
                     int'($urandom_range(0, 4)), 1'b1, 1'b0);
        end

        // Reset in the middle of CONVERT.
        start_conv();
        for (int c = 0; c < SC + 3; c++) begin
            drive_cmp(1'b1);
            step();
        end
        chk("pre_reset_conv", 32'(ctl()), 32'(c_CONV));
        rst_n = 1'b0;
        step();
        chk("midreset_ctl", 32'(ctl()), 32'(c_IDLE));
        chk("midreset_data", 32'(res_data), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 32'(ctl()), 32'(c_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
